// File: rtl/alu_arbiter_if.sv
// Handshake and bus bundle between two requesters, the shared ALU and the
// response consumer of alu_arbiter.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_sel;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_sel;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_r;
    logic             alu_zf;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_r;
    logic             rsp_zf;
    logic             rsp_err;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sel,
        output req1_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_r, alu_zf,
        output rsp_valid, rsp_id, rsp_r, rsp_zf, rsp_err, busy,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sel,
        input  req1_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_r, alu_zf,
        input  rsp_valid, rsp_id, rsp_r, rsp_zf, rsp_err, busy,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: accept (IDLE) -> EXEC (one cycle) -> RESP (until
// the consumer takes the response).
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             grant;
    logic             rdy0;
    logic             rdy1;
    logic             accept;
    logic             div_zero;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       op_sel;
    logic             op_id;
    logic [WIDTH-1:0] rsp_r_q;
    logic             rsp_zf_q;
    logic             rsp_err_q;

    // pick the sole requester, or alternate against last_grant on a tie
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    // ready generation and next-state decode
    always_comb begin
        state_nxt = state;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        case (state)
            IDLE: begin
                // readies are gated by rst_n so they stay low while reset is held
                rdy0 = rst_n && bus.req0_valid && !grant;
                rdy1 = rst_n && bus.req1_valid && grant;
                if (rdy0 || rdy1) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept   = rdy0 || rdy1;
    assign div_zero = (op_sel == 3'd6) && (op_b == '0);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // operand capture on accept, result capture at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= '0;
            op_id      <= 1'b0;
            rsp_r_q    <= '0;
            rsp_zf_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_a       <= rdy1 ? bus.req1_a   : bus.req0_a;
                op_b       <= rdy1 ? bus.req1_b   : bus.req0_b;
                op_sel     <= rdy1 ? bus.req1_sel : bus.req0_sel;
                op_id      <= rdy1;
                last_grant <= rdy1;
            end
            if (state == EXEC) begin
                if (div_zero) begin
                    rsp_r_q   <= '1;
                    rsp_zf_q  <= 1'b0;
                    rsp_err_q <= 1'b1;
                end else begin
                    rsp_r_q   <= bus.alu_r;
                    rsp_zf_q  <= bus.alu_zf;
                    rsp_err_q <= 1'b0;
                end
            end
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.alu_a      = op_a;
    assign bus.alu_b      = op_b;
    assign bus.alu_sel    = op_sel;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = op_id;
    assign bus.rsp_r      = rsp_r_q;
    assign bus.rsp_zf     = rsp_zf_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: the driver predicts the grant and the
// response of every accepted request; a monitor checks protocol and results.
`timescale 1ns/1ps
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(32)) bus();

    alu_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] r;
        logic        zf;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   model_last = 1'b1;

    // shared ALU environment model; divide by zero returns 0 so an
    // un-overridden result is visible
    function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] sel);
        case (sel)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return {31'b0, (a != 0) && (b != 0)};
            3'd3: return {31'b0, (a != 0) || (b != 0)};
            3'd4: return {31'b0, a < b};
            3'd5: return a * b;
            3'd6: return (b == 0) ? 32'h0 : a / b;
            default: return b;
        endcase
    endfunction

    logic [31:0] alu_res;
    assign alu_res    = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);
    assign bus.alu_r  = alu_res;
    assign bus.alu_zf = (alu_res == 32'h0);

    // expected response from the operation's definition
    function automatic rsp_t ref_rsp(logic id, logic [31:0] a, logic [31:0] b, logic [2:0] sel);
        rsp_t        e;
        logic [63:0] p;
        e.id  = id;
        e.err = 1'b0;
        e.r   = 32'h0;
        case (sel)
            3'd0: e.r = a + b;
            3'd1: e.r = a - b;
            3'd2: e.r = (a != 0 && b != 0) ? 32'd1 : 32'd0;
            3'd3: e.r = (a != 0 || b != 0) ? 32'd1 : 32'd0;
            3'd4: e.r = (a < b) ? 32'd1 : 32'd0;
            3'd5: begin
                p   = {32'b0, a} * {32'b0, b};
                e.r = p[31:0];
            end
            3'd6: begin
                if (b == 0) begin
                    e.r   = 32'hFFFF_FFFF;
                    e.err = 1'b1;
                end else begin
                    e.r = a / b;
                end
            end
            default: e.r = b;
        endcase
        e.zf = !e.err && (e.r == 32'h0);
        return e;
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
    endtask

    task automatic scramble();
        bus.req0_valid = 1'($urandom);
        bus.req1_valid = 1'($urandom);
        bus.req0_a     = $urandom;
        bus.req0_b     = $urandom;
        bus.req0_sel   = 3'($urandom);
        bus.req1_a     = $urandom;
        bus.req1_b     = $urandom;
        bus.req1_sel   = 3'($urandom);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 3))
            0: return 32'h0;
            1: return 32'($urandom_range(0, 7));
            default: return $urandom;
        endcase
    endfunction

    // present the requests and wait for an accept; predict winner and response
    task automatic wait_accept(bit v0, logic [31:0] a0, logic [31:0] b0, logic [2:0] s0,
                               bit v1, logic [31:0] a1, logic [31:0] b1, logic [2:0] s1,
                               output bit got);
        bit win;
        got = 1'b0;
        bus.req0_valid = v0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req0_sel   = s0;
        bus.req1_valid = v1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
        bus.req1_sel   = s1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                got = 1'b1;
                win = (v0 && v1) ? !model_last : v1;
                check("grant", {bus.req0_ready, bus.req1_ready}, {!win, win});
                sb.push_back(win ? ref_rsp(1'b1, a1, b1, s1) : ref_rsp(1'b0, a0, b0, s0));
                model_last = win;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got no ready expected a ready within 8 cycles");
        end
    endtask

    // one full operation; stall = RESP cycles held with rsp_ready low
    task automatic do_op(bit v0, logic [31:0] a0, logic [31:0] b0, logic [2:0] s0,
                         bit v1, logic [31:0] a1, logic [31:0] b1, logic [2:0] s1,
                         int stall);
        bit got;
        bit hs;
        hs = 1'b0;
        bus.rsp_ready = 1'b0;
        wait_accept(v0, a0, b0, s0, v1, a1, b1, s1, got);
        if (got) begin
            for (int cyc = 0; cyc < 20 && !hs; cyc++) begin
                scramble();
                bus.rsp_ready = (cyc > stall);
                @(negedge clk);
                hs = bus.rsp_valid && bus.rsp_ready;
                @(posedge clk);
                #1;
            end
            if (!hs) begin
                tests++;
                fails++;
                $display("FAIL rsp_timeout: got no response handshake expected one within 20 cycles");
            end
        end
        idle_inputs();
    endtask

    // protocol and result monitor
    int   mon_age = -1;
    bit   mon_held = 1'b0;
    bit   mon_hs_prev = 1'b0;
    rsp_t mon_hv;
    initial begin
        rsp_t cur;
        rsp_t e;
        forever begin
            @(negedge clk);
            cur = '{bus.rsp_id, bus.rsp_r, bus.rsp_zf, bus.rsp_err};
            if (!rst_n) begin
                check("reset_ctl", {bus.rsp_valid, bus.busy, bus.req0_ready, bus.req1_ready}, 4'b0);
                check("reset_rsp", cur, '0);
                check("reset_ops", {bus.alu_a, bus.alu_b, bus.alu_sel}, '0);
                mon_age     = -1;
                mon_held    = 1'b0;
                mon_hs_prev = 1'b0;
            end else begin
                if (mon_age >= 0) mon_age++;
                if (mon_age > 2) mon_age = -1;
                if (mon_hs_prev) check("idle_after_rsp", bus.busy, 1'b0);
                if (bus.busy) check("ready_while_busy", {bus.req0_ready, bus.req1_ready}, 2'b00);
                else check("ready_exclusive", bus.req0_ready && bus.req1_ready, 1'b0);
                if (mon_age == 1) check("exec_phase", {bus.rsp_valid, bus.busy}, 2'b01);
                if (mon_age == 2) check("resp_latency", bus.rsp_valid, 1'b1);
                if (mon_held) check("rsp_hold", {bus.rsp_valid, cur}, {1'b1, mon_hv});
                mon_hs_prev = bus.rsp_valid && bus.rsp_ready;
                if (mon_hs_prev) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_rsp: got id=%0d r=%0h expected no response", bus.rsp_id, bus.rsp_r);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_id", bus.rsp_id, e.id);
                        check("rsp_r", bus.rsp_r, e.r);
                        check("rsp_zf", bus.rsp_zf, e.zf);
                        check("rsp_err", bus.rsp_err, e.err);
                    end
                end
                mon_held = bus.rsp_valid && !bus.rsp_ready;
                mon_hv   = cur;
                if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready))
                    mon_age = 0;
            end
        end
    end

    initial begin
        bit got;
        bit v0;
        bit v1;
        scramble();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_inputs();

        // ties from reset: req0, req1, then req0 again
        do_op(1, 32'd1, 32'd1, 3'd0, 1, 32'd4, 32'd4, 3'd5, 0);
        do_op(1, 32'd1, 32'd1, 3'd0, 1, 32'd4, 32'd4, 3'd5, 0);
        do_op(1, 32'd1, 32'd1, 3'd0, 1, 32'd4, 32'd4, 3'd5, 0);
        do_op(1, 32'd5, 32'd3, 3'd1, 0, 32'd0, 32'd0, 3'd0, 0);
        // divide by zero, then a normal divide
        do_op(0, 32'd0, 32'd0, 3'd0, 1, 32'd9, 32'd0, 3'd6, 0);
        do_op(0, 32'd0, 32'd0, 3'd0, 1, 32'd9, 32'd3, 3'd6, 0);
        // backpressure with a zero result
        do_op(1, 32'd7, 32'd7, 3'd1, 0, 32'd0, 32'd0, 3'd0, 5);
        do_op(1, 32'd2, 32'd3, 3'd4, 0, 32'd0, 32'd0, 3'd0, 0);
        do_op(0, 32'd0, 32'd0, 3'd0, 1, 32'd0, 32'd0, 3'd7, 1);

        // reset during EXEC aborts the operation
        wait_accept(1, 32'd8, 32'd2, 3'd0, 0, 32'd0, 32'd0, 3'd0, got);
        rst_n = 1'b0;
        sb.delete();
        model_last = 1'b1;
        idle_inputs();
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        idle_inputs();
        do_op(1, 32'd3, 32'd0, 3'd3, 1, 32'd6, 32'd7, 3'd2, 0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            do_op(v0, rand_opnd(), rand_opnd(), 3'($urandom),
                  v1, rand_opnd(), rand_opnd(), 3'($urandom),
                  int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
